// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Purpose : operand/result bundle between the execute-stage controller and the
//           iterative multiply/divide unit.
// Signals :
//   start      1      request pulse (controller -> unit)
//   op         3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   opr1       WIDTH  multiplicand / dividend / MTHI-MTLO source
//   opr2       WIDTH  multiplier / divisor
//   busy       1      iterative operation in flight
//   done       1      one-cycle pulse, hi/lo valid in this cycle
//   divByZero  1      qualifies done for a DIV/DIVU with opr2 == 0
//   hi, lo     WIDTH  HI/LO architectural registers
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and op
// is one of the six defined codes; opr1/opr2/op are only sampled on that
// edge. Requests seen while busy=1 are dropped, not queued. Every accepted
// request produces exactly one done pulse; done and busy are never high in
// the same cycle, so a new start may be presented in the done cycle.
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opr1;
  logic [WIDTH-1:0] opr2;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opr1, opr2,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, opr1, opr2,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Purpose : iterative radix-2 multiply/divide unit owning the HI/LO pair.
//           MULT/MULTU/DIV/DIVU take WIDTH CALC clocks plus one FIX clock;
//           MTHI/MTLO write in a single edge. Divide by zero skips CALC.
// Ports   :
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   bus      slave modport of mul_div_unit_if (start/op/opr1/opr2 in,
//            busy/done/divByZero/hi/lo out)
//   state_o  out  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] DIVZERO_LO = {WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  mul_div_unit_if.slave       bus,
  output logic [1:0]          state_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  // a_q: multiplier shifting out / dividend shifting out, quotient shifting in.
  // b_q: multiplicand / divisor magnitude.
  // p_q: upper product half / partial remainder.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic             is_div_q;
  logic             dz_q;
  logic             neg_lo_q;   // product / quotient sign
  logic             neg_hi_q;   // remainder sign (follows the dividend)
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Operand magnitudes: only signed ops look at the sign bits.
  logic             signed_op;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign s1        = signed_op & bus.opr1[WIDTH-1];
  assign s2        = signed_op & bus.opr2[WIDTH-1];
  assign mag1      = s1 ? (~bus.opr1 + 1'b1) : bus.opr1;
  assign mag2      = s2 ? (~bus.opr2 + 1'b1) : bus.opr2;

  // Multiply step: add multiplicand when the low multiplier bit is set, then
  // shift {carry, p, a} right by one; product bits fill a from the top.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, p_q} + {1'b0, (a_q[0] ? b_q : '0)};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The shifted remainder needs WIDTH+1
  // bits; after a successful subtract the result always fits in WIDTH.
  logic [WIDTH:0]   div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  assign div_rem = {p_q, a_q[WIDTH-1]};
  assign div_ge  = (div_rem >= {1'b0, b_q});
  assign div_sub = div_rem[WIDTH-1:0] - b_q;

  // Sign fix-up applied on the FIX edge.
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_raw = {p_q, a_q};
  assign prod_fix = neg_lo_q ? (~prod_raw + 1'b1) : prod_raw;
  assign quot_fix = neg_lo_q ? (~a_q + 1'b1) : a_q;
  assign rem_fix  = neg_hi_q ? (~p_q + 1'b1) : p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                b_q      <= mag2;
                p_q      <= '0;
                cnt_q    <= '0;
                is_div_q <= bus.op[1];
                neg_lo_q <= s1 ^ s2;
                neg_hi_q <= s1;
                busy_q   <= 1'b1;
                if (bus.op[1] && (bus.opr2 == '0)) begin
                  // Keep the raw dividend: it becomes HI unchanged.
                  a_q     <= bus.opr1;
                  dz_q    <= 1'b1;
                  state_q <= S_FIX;
                end else begin
                  a_q     <= mag1;
                  dz_q    <= 1'b0;
                  state_q <= S_CALC;
                end
              end
              OP_MTHI: begin
                hi_q   <= bus.opr1;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.opr1;
                done_q <= 1'b1;
              end
              default: ;  // undefined codes are dropped silently
            endcase
          end
        end

        S_CALC: begin
          if (is_div_q) begin
            p_q <= div_ge ? div_sub : div_rem[WIDTH-1:0];
            a_q <= {a_q[WIDTH-2:0], div_ge};
          end else begin
            p_q <= mul_sum[WIDTH:1];
            a_q <= {mul_sum[0], a_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          if (dz_q) begin
            hi_q <= a_q;
            lo_q <= DIVZERO_LO;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          dbz_q   <= dz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.divByZero = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Stimulus tasks push the expected {divByZero, hi, lo} and the expected done
// cycle into queues; a monitor forked from the main process pops and compares
// on every done pulse. The reference model uses plain 64-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(
    .WIDTH      (W),
    .DIVZERO_LO (32'hFFFFFFFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int             total = 0;
  int             bad   = 0;
  logic [2*W:0]   exp_q[$];   // {divByZero, hi, lo}
  int             lat_q[$];   // cycle count at which done must be seen
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  logic [1:0]     idle_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic dz, output int lat);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        p;
    sa  = {{32{a[W-1]}}, a};
    sb  = {{32{b[W-1]}}, b};
    dz  = 1'b0;
    lat = 34;
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          dz = 1'b1; lat = 2; m_hi = a; m_lo = 32'hFFFFFFFF;
        end else if (op == 3'd2) begin
          sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      3'd4: begin m_hi = a; lat = 1; end
      default: begin m_lo = a; lat = 1; end
    endcase
  endtask

  // ---------------- driver tasks (entered at a negedge) ----------------
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic dz;
    int   lat;
    bus.start = 1'b1;
    bus.op    = op;
    bus.opr1  = a;
    bus.opr2  = b;
    if (op <= 3'd5) begin
      model(op, a, b, dz, lat);
      exp_q.push_back({dz, m_hi, m_lo});
      lat_q.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.opr1  = $urandom;
    bus.opr2  = $urandom;
    bus.op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input logic [W-1:0] ph, input logic [W-1:0] pl, input logic exp_busy);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        check("busy_in_flight", bus.busy, exp_busy);
        check("hi_hold", bus.hi, ph);
        check("lo_hold", bus.lo, pl);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 60 cycles, required a done pulse");
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit intrude);
    logic [W-1:0] ph, pl;
    ph = m_hi;
    pl = m_lo;
    issue(op, a, b);
    if (intrude && op < 3'd4 && !(op[1] && b == 0)) begin
      // A DIV request during the operation must be dropped.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 3'd2;
      bus.opr1  = $urandom;
      bus.opr2  = $urandom;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    wait_done(ph, pl, op < 3'd4);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [2*W:0] e;
    int           l;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        check("busy_at_done", bus.busy, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("done_cycle", cyc, l);
          check("hi", bus.hi, e[2*W-1:W]);
          check("lo", bus.lo, e[W-1:0]);
          check("divByZero", bus.divByZero, e[2*W]);
        end
      end else begin
        check("dbz_without_done", bus.divByZero, 0);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.opr1  = '0;
    bus.opr2  = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.divByZero, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    idle_code = state_dbg;
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a MULT: no done, HI/LO cleared
    run_op(3'd4, 32'h11112222, 0, 1'b0);
    issue(3'd0, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(negedge clk);
    check("midop_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_hi", bus.hi, 0);
    check("midrst_lo", bus.lo, 0);
    exp_q.delete();
    lat_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Directed corners, issued back to back in each done cycle
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_hi", bus.hi, 32'hFFFFFFFE);
    check("multu_lo", bus.lo, 32'h00000001);
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("mult_hi", bus.hi, 32'h0);
    check("mult_lo", bus.lo, 32'h1);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_neg_lo", bus.lo, 32'hFFFFFFFD);
    check("div_neg_hi", bus.hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'd7, 32'd2, 1'b0);
    check("divu_lo", bus.lo, 32'd3);
    check("divu_hi", bus.hi, 32'd1);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_wrap_lo", bus.lo, 32'h80000000);
    check("div_wrap_hi", bus.hi, 32'h0);
    run_op(3'd3, 32'h1234, 32'h0, 1'b0);
    check("divz_dbz", bus.divByZero, 1);
    check("divz_hi", bus.hi, 32'h1234);
    check("divz_lo", bus.lo, 32'hFFFFFFFF);
    run_op(3'd2, 32'h80000001, 32'h0, 1'b0);
    run_op(3'd4, 32'hA5A5A5A5, 32'h0, 1'b0);
    run_op(3'd5, 32'h5A5A5A5A, 32'h0, 1'b0);
    check("mt_hi", bus.hi, 32'hA5A5A5A5);
    check("mt_lo", bus.lo, 32'h5A5A5A5A);

    // Start during busy is ignored
    run_op(3'd1, 32'h0000BEEF, 32'h00010001, 1'b1);
    check("intrude_lo", bus.lo, 32'hBEEFBEEF);
    check("intrude_hi", bus.hi, 32'h0);

    // Undefined op codes do nothing
    issue(3'd6, $urandom, $urandom);
    issue(3'd7, $urandom, $urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("undef_busy", bus.busy, 0);
      check("undef_hi", bus.hi, m_hi);
      check("undef_lo", bus.lo, m_lo);
    end

    // Random operations
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 5)), pick(), pick(), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    check("fsm_idle", state_dbg, idle_code);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
